// File: rtl/peripheral_mtimer_ahb4_if.sv
// AHB4-Lite slave bus bundle for the multi-channel timer peripheral.
interface peripheral_mtimer_ahb4_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADYOUT;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/peripheral_mtimer_ahb4.sv
// Multi-channel AHB4-Lite timer: one global prescaler feeding TIMERS
// periodic/one-shot compare channels with W1C pending and registered interrupts.
module peripheral_mtimer_ahb4 #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int TIMERS     = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    peripheral_mtimer_ahb4_if.slave ahb,
    output logic [TIMERS-1:0]     tint_ch,
    output logic                  tint
);
    logic                 gen_q, gen_d;
    logic [31:0]          prescale_q, prescale_d;
    logic [31:0]          pcnt_q, pcnt_d;
    logic [TIMERS-1:0]    ipend_q, ipend_d;
    logic [TIMERS-1:0]    ien_q, ien_d;
    logic [TIMERS-1:0]    en_q, en_d;
    logic [TIMERS-1:0]    os_q, os_d;
    logic [CNT_WIDTH-1:0] count_q [TIMERS];
    logic [CNT_WIDTH-1:0] count_d [TIMERS];
    logic [CNT_WIDTH-1:0] cmp_q   [TIMERS];
    logic [CNT_WIDTH-1:0] cmp_d   [TIMERS];
    logic [TIMERS-1:0]    tint_ch_q;
    logic                 tint_q;

    logic                 wr_q;
    logic [9:0]           waddr_q;
    logic [3:0]           wbe_q;
    logic [31:0]          rdata_q;

    logic                 ap_valid;
    logic [3:0]           ap_be;
    logic [31:0]          rmux;
    logic [31:0]          wdata;
    logic [31:0]          wmask;
    logic                 tick;
    logic                 presc_wr;
    logic [TIMERS-1:0]    w1c;
    logic [TIMERS-1:0]    hw_set;
    logic [TIMERS-1:0]    ch_wr;
    logic                 unused_ok;

    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;
    assign ahb.HRDATA    = rdata_q;
    assign tint_ch       = tint_ch_q;
    assign tint          = tint_q;
    assign unused_ok     = ^{ahb.HBURST, ahb.HPROT, ahb.HTRANS[0], ahb.HADDR[HADDR_SIZE-1:12]};

    // Only NONSEQ/SEQ transfers are real; the register map aliases every 4 KiB.
    assign ap_valid = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign wdata    = ahb.HWDATA[31:0];
    assign wmask    = {{8{wbe_q[3]}}, {8{wbe_q[2]}}, {8{wbe_q[1]}}, {8{wbe_q[0]}}};
    assign tick     = gen_q & (pcnt_q == 32'd0);

    always_comb begin
        ap_be = 4'b1111;
        case (ahb.HSIZE)
            3'b000:  ap_be = 4'b0001 << ahb.HADDR[1:0];
            3'b001:  ap_be = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            default: ap_be = 4'b1111;
        endcase
    end

    always_comb begin
        rmux = '0;
        if (ahb.HADDR[11:4] == 8'd0) begin
            case (ahb.HADDR[3:2])
                2'd0: rmux = {31'd0, gen_q};
                2'd1: rmux = prescale_q;
                2'd2: rmux[TIMERS-1:0] = ipend_q;
                2'd3: rmux[TIMERS-1:0] = ien_q;
                default: ;
            endcase
        end
        for (int n = 0; n < TIMERS; n++) begin
            if (ahb.HADDR[11:4] == 8'(n + 2)) begin
                case (ahb.HADDR[3:2])
                    2'd0: rmux = {30'd0, os_q[n], en_q[n]};
                    2'd1: rmux[CNT_WIDTH-1:0] = count_q[n];
                    2'd2: rmux[CNT_WIDTH-1:0] = cmp_q[n];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        gen_d      = gen_q;
        prescale_d = prescale_q;
        ien_d      = ien_q;
        en_d       = en_q;
        os_d       = os_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        presc_wr   = 1'b0;
        w1c        = '0;
        hw_set     = '0;
        ch_wr      = '0;

        if (wr_q && waddr_q[9:2] == 8'd0) begin
            case (waddr_q[1:0])
                2'd0: gen_d = (gen_q & ~wmask[0]) | (wdata[0] & wmask[0]);
                2'd1: begin
                    prescale_d = (prescale_q & ~wmask) | (wdata & wmask);
                    presc_wr   = 1'b1;
                end
                2'd2: w1c = wdata[TIMERS-1:0] & wmask[TIMERS-1:0];
                2'd3: ien_d = (ien_q & ~wmask[TIMERS-1:0]) | (wdata[TIMERS-1:0] & wmask[TIMERS-1:0]);
                default: ;
            endcase
        end

        for (int n = 0; n < TIMERS; n++) begin
            if (wr_q && waddr_q[9:2] == 8'(n + 2)) begin
                case (waddr_q[1:0])
                    2'd0: begin
                        ch_wr[n] = 1'b1;
                        en_d[n]  = (en_q[n] & ~wmask[0]) | (wdata[0] & wmask[0]);
                        os_d[n]  = (os_q[n] & ~wmask[1]) | (wdata[1] & wmask[1]);
                    end
                    2'd1: begin
                        ch_wr[n]   = 1'b1;
                        count_d[n] = (count_q[n] & ~wmask[CNT_WIDTH-1:0])
                                   | (wdata[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0]);
                    end
                    2'd2: begin
                        ch_wr[n] = 1'b1;
                        cmp_d[n] = (cmp_q[n] & ~wmask[CNT_WIDTH-1:0])
                                 | (wdata[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0]);
                    end
                    default: ;
                endcase
            end
            // A bus write to this channel's registers suppresses the whole tick update.
            if (tick && en_q[n] && !ch_wr[n]) begin
                if (count_q[n] == cmp_q[n]) begin
                    hw_set[n] = 1'b1;
                    if (os_q[n]) en_d[n] = 1'b0;
                    else         count_d[n] = '0;
                end else begin
                    count_d[n] = count_q[n] + 1'b1;
                end
            end
        end

        ipend_d = (ipend_q & ~w1c) | hw_set;

        if (!gen_q || tick) pcnt_d = prescale_q;
        else                pcnt_d = pcnt_q - 32'd1;
        if (presc_wr)       pcnt_d = prescale_d;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wbe_q   <= '0;
            rdata_q <= '0;
        end else begin
            wr_q <= ap_valid & ahb.HWRITE;
            if (ap_valid) begin
                waddr_q <= ahb.HADDR[11:2];
                wbe_q   <= ap_be;
            end
            if (ap_valid && !ahb.HWRITE) rdata_q <= rmux;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gen_q      <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            ipend_q    <= '0;
            ien_q      <= '0;
            en_q       <= '0;
            os_q       <= '0;
            tint_ch_q  <= '0;
            tint_q     <= 1'b0;
            for (int n = 0; n < TIMERS; n++) begin
                count_q[n] <= '0;
                cmp_q[n]   <= '0;
            end
        end else begin
            gen_q      <= gen_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            ipend_q    <= ipend_d;
            ien_q      <= ien_d;
            en_q       <= en_d;
            os_q       <= os_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            tint_ch_q  <= ipend_q & ien_q;
            tint_q     <= |(ipend_q & ien_q);
        end
    end
endmodule

// File: tb/tb_peripheral_mtimer_ahb4.sv
// Randomised self-checking bench: a 32-bit-counter instance plus an 8-bit-counter
// instance share one AHB stimulus; expectations come from arithmetic timing rules.
module tb_peripheral_mtimer_ahb4;
    localparam logic [31:0] A_GCTRL = 32'h00, A_PRESC = 32'h04, A_IPEND = 32'h08, A_IEN = 32'h0C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [2:0]  hsize = 3'b010;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hrdata_a, hrdata_b, rd_b;
    logic [3:0]  tint_ch_a, tint_ch_b;
    logic        tint_a, tint_b;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    peripheral_mtimer_ahb4_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus_a ();
    peripheral_mtimer_ahb4_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus_b ();

    assign bus_a.HSEL = hsel;     assign bus_b.HSEL = hsel;
    assign bus_a.HADDR = haddr;   assign bus_b.HADDR = haddr;
    assign bus_a.HWDATA = hwdata; assign bus_b.HWDATA = hwdata;
    assign bus_a.HWRITE = hwrite; assign bus_b.HWRITE = hwrite;
    assign bus_a.HSIZE = hsize;   assign bus_b.HSIZE = hsize;
    assign bus_a.HBURST = 3'b000; assign bus_b.HBURST = 3'b000;
    assign bus_a.HPROT = 4'b0011; assign bus_b.HPROT = 4'b0011;
    assign bus_a.HTRANS = htrans; assign bus_b.HTRANS = htrans;
    assign bus_a.HREADY = 1'b1;   assign bus_b.HREADY = 1'b1;
    assign hrdata_a = bus_a.HRDATA;
    assign hrdata_b = bus_b.HRDATA;

    peripheral_mtimer_ahb4 #(.HADDR_SIZE(32), .HDATA_SIZE(32), .TIMERS(4), .CNT_WIDTH(32)) dut_a (
        .HCLK(clk), .HRESETn(rst_n), .ahb(bus_a), .tint_ch(tint_ch_a), .tint(tint_a));
    peripheral_mtimer_ahb4 #(.HADDR_SIZE(32), .HDATA_SIZE(32), .TIMERS(4), .CNT_WIDTH(8)) dut_b (
        .HCLK(clk), .HRESETn(rst_n), .ahb(bus_b), .tint_ch(tint_ch_b), .tint(tint_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All bus tasks start and end 1 ns after a rising edge.
    task automatic ahb_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a; hsize = sz;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ahb_wr(a, d, 3'b010);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        d = hrdata_a;
        rd_b = hrdata_b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_tint(input int limit, output int t);
        int k;
        k = 0;
        while (tint_a !== 1'b1 && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        t = (tint_a === 1'b1) ? cyc : -1;
    endtask

    function automatic logic [31:0] vmask(input int w);
        if (w == 1) return 32'hFFFF_FFFF;
        if (w == 3) return 32'h0000_000F;
        if (w >= 8 && w < 24) begin
            case ((w - 8) % 4)
                0: return 32'h3;
                1, 2: return 32'hFFFF_FFFF;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic test_reset();
        logic [31:0] r;
        rst_n = 1'b0;
        #2;
        total++;
        if (tint_a !== 1'b0 || tint_ch_a !== 4'h0) begin
            bad++; $display("FAIL reset_async_tint: tint=%b tint_ch=%h required 0/0", tint_a, tint_ch_a);
        end
        do_reset();
        total++;
        if (bus_a.HREADYOUT !== 1'b1 || bus_a.HRESP !== 1'b0 || bus_b.HREADYOUT !== 1'b1 || bus_b.HRESP !== 1'b0) begin
            bad++; $display("FAIL reset_ready_resp: readyout=%b resp=%b required 1/0", bus_a.HREADYOUT, bus_a.HRESP);
        end
        total++;
        if (tint_a !== 1'b0 || tint_ch_a !== 4'h0 || tint_b !== 1'b0 || tint_ch_b !== 4'h0) begin
            bad++; $display("FAIL reset_tint: tint=%b tint_ch=%h required 0", tint_a, tint_ch_a);
        end
        for (int w = 0; w < 24; w++) begin
            if (w >= 4 && w < 8) continue;
            rd(w * 4, r);
            total++;
            if (r !== 32'h0) begin
                bad++; $display("FAIL reset_reg[%0h]: got %h required 0", w * 4, r);
            end
        end
    endtask

    task automatic test_readback();
        logic [31:0] shadow [28];
        logic [31:0] r, d, m, a;
        int w, sz, b, rw;
        do_reset();
        wr(A_IEN, 32'hFFFF_FFFF);
        rd(A_IEN, r);
        total++;
        if (r !== 32'hF) begin bad++; $display("FAIL ienable_width: got %h required 0000000f", r); end
        wr(32'h60, 32'h08);
        rd(32'h60, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL unmapped_0x60: got %h required 0", r); end
        wr(A_IEN, 32'h0);
        for (int i = 0; i < 28; i++) shadow[i] = 32'h0;
        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(1, 27);
            if (w == 2) w = 3;
            sz = $urandom_range(0, 2);
            d = $urandom();
            case (sz)
                0: begin b = $urandom_range(0, 3); a = w * 4 + b;     m = 32'hFF << (8 * b); end
                1: begin b = $urandom_range(0, 1); a = w * 4 + 2 * b; m = 32'hFFFF << (16 * b); end
                default: begin a = w * 4; m = 32'hFFFF_FFFF; end
            endcase
            ahb_wr(a, d, 3'(sz));
            shadow[w] = ((shadow[w] & ~m) | (d & m)) & vmask(w);
            rw = $urandom_range(1, 27);
            rd(rw * 4, r);
            total++;
            if (r !== shadow[rw]) begin
                bad++; $display("FAIL rand_readback[%0h]: got %h required %h", rw * 4, r, shadow[rw]);
            end
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] r;
        do_reset();
        wr(32'h48, 32'h1234_5678);
        ahb_wr(32'h49, 32'h0000_AB00, 3'b000);
        rd(32'h48, r);
        total++;
        if (r !== 32'h1234_AB78) begin bad++; $display("FAIL byte_write: got %h required 1234ab78", r); end
        ahb_wr(32'h4A, 32'hCDEF_0000, 3'b001);
        rd(32'h48, r);
        total++;
        if (r !== 32'hCDEF_AB78) begin bad++; $display("FAIL half_write: got %h required cdefab78", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2, r;
        do_reset();
        d1 = $urandom(); d2 = $urandom();
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h58; hsize = 3'b010;
        @(posedge clk); #1;
        haddr = 32'h54; htrans = 2'b10; hwdata = d1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d2;
        @(posedge clk); #1;
        rd(32'h58, r);
        total++;
        if (r !== d1) begin bad++; $display("FAIL b2b_first: got %h required %h", r, d1); end
        rd(32'h54, r);
        total++;
        if (r !== d2) begin bad++; $display("FAIL b2b_second: got %h required %h", r, d2); end
    endtask

    task automatic test_periodic(input int p, input int c);
        logic [31:0] r;
        int t0, t1, t2, per;
        per = (p + 1) * (c + 1);
        do_reset();
        wr(A_PRESC, p);
        wr(32'h28, c);
        wr(32'h20, 32'h1);
        wr(A_IEN, 32'h1);
        wr(A_GCTRL, 32'h1);
        t0 = cyc;
        wait_tint(per + 10, t1);
        total++;
        if (t1 - t0 !== per + 1) begin
            bad++; $display("FAIL periodic_first p=%0d c=%0d: tint after %0d cycles required %0d", p, c, t1 - t0, per + 1);
        end
        rd(A_IPEND, r);
        total++;
        if (r !== 32'h1) begin bad++; $display("FAIL periodic_pending: got %h required 1", r); end
        rd(32'h24, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL periodic_count_reload: got %h required 0", r); end
        wr(A_IPEND, 32'h1);
        total++;
        if (tint_a !== 1'b1) begin bad++; $display("FAIL periodic_tint_latency: got %b required 1", tint_a); end
        @(posedge clk); #1;
        total++;
        if (tint_a !== 1'b0) begin bad++; $display("FAIL periodic_tint_clear: got %b required 0", tint_a); end
        wait_tint(per + 10, t2);
        total++;
        if (t2 - t1 !== per) begin
            bad++; $display("FAIL periodic_second p=%0d c=%0d: spacing %0d required %0d", p, c, t2 - t1, per);
        end
    endtask

    task automatic test_oneshot(input int c);
        logic [31:0] r;
        int t0, t1;
        bit again;
        do_reset();
        wr(A_PRESC, 32'h0);
        wr(32'h38, c);
        wr(32'h30, 32'h3);
        wr(A_IEN, 32'h2);
        wr(A_GCTRL, 32'h1);
        t0 = cyc;
        wait_tint(c + 20, t1);
        total++;
        if (t1 - t0 !== c + 2) begin
            bad++; $display("FAIL oneshot_time c=%0d: tint after %0d cycles required %0d", c, t1 - t0, c + 2);
        end
        total++;
        if (tint_ch_a !== 4'b0010) begin bad++; $display("FAIL oneshot_tint_ch: got %b required 0010", tint_ch_a); end
        rd(32'h30, r);
        total++;
        if (r !== 32'h2) begin bad++; $display("FAIL oneshot_ctrl: got %h required 2", r); end
        rd(32'h34, r);
        total++;
        if (r !== 32'(c)) begin bad++; $display("FAIL oneshot_count: got %h required %h", r, c); end
        wr(A_IPEND, 32'h2);
        @(posedge clk); #1;
        again = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tint_a === 1'b1) again = 1'b1;
        end
        total++;
        if (again !== 1'b0) begin bad++; $display("FAIL oneshot_retrigger: got %b required 0", again); end
        rd(A_IPEND, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL oneshot_pending_after: got %h required 0", r); end
    endtask

    task automatic test_collision_w1c();
        logic [31:0] r;
        do_reset();
        wr(32'h28, 32'h0);
        wr(32'h20, 32'h1);
        wr(A_GCTRL, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        wr(A_IPEND, 32'h1);
        rd(A_IPEND, r);
        total++;
        if (r !== 32'h1) begin bad++; $display("FAIL w1c_collision: got %h required 1", r); end
        total++;
        if (tint_a !== 1'b0) begin bad++; $display("FAIL ienable_gating: tint=%b required 0", tint_a); end
        wr(A_IEN, 32'h1);
        total++;
        if (tint_a !== 1'b0) begin bad++; $display("FAIL ienable_latency: tint=%b required 0", tint_a); end
        @(posedge clk); #1;
        total++;
        if (tint_a !== 1'b1) begin bad++; $display("FAIL ienable_rise: tint=%b required 1", tint_a); end
    endtask

    task automatic test_collision_count();
        logic [31:0] r;
        do_reset();
        wr(32'h28, 32'hFFFF);
        wr(32'h20, 32'h1);
        wr(A_GCTRL, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        wr(32'h24, 32'h10);
        rd(32'h24, r);
        total++;
        if (r !== 32'h10) begin bad++; $display("FAIL count_write_vs_tick: got %h required 00000010", r); end
    endtask

    task automatic test_wrap();
        logic [31:0] r;
        int exp_cnt;
        bit exp_pend;
        do_reset();
        wr(32'h24, 32'hFFFF_FF12);
        rd(32'h24, r);
        total++;
        if (rd_b !== 32'h12) begin bad++; $display("FAIL narrow_count_upper: got %h required 00000012", rd_b); end
        wr(32'h24, 32'hFF);
        wr(32'h28, 32'h02);
        wr(32'h20, 32'h1);
        wr(A_IEN, 32'h1);
        wr(A_GCTRL, 32'h1);
        exp_cnt = 8'hFF;
        exp_pend = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(32'h24, r);
            total++;
            if (rd_b !== 32'(exp_cnt)) begin
                bad++; $display("FAIL wrap_count[%0d]: got %h required %h", i, rd_b, exp_cnt);
            end
            if (exp_cnt == 2) begin exp_pend = 1'b1; exp_cnt = 0; end
            else exp_cnt = (exp_cnt + 1) % 256;
        end
        rd(A_IPEND, r);
        total++;
        if (rd_b !== 32'(exp_pend)) begin bad++; $display("FAIL wrap_pending: got %h required %h", rd_b, exp_pend); end
        total++;
        if (tint_b !== 1'b1 || tint_ch_b !== 4'b0001) begin
            bad++; $display("FAIL wrap_tint: tint=%b tint_ch=%b required 1/0001", tint_b, tint_ch_b);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_readback();
        test_byte_write();
        test_back_to_back();
        test_periodic(2, 3);
        test_periodic($urandom_range(1, 3), $urandom_range(2, 5));
        test_oneshot(5);
        test_oneshot($urandom_range(2, 9));
        test_collision_w1c();
        test_collision_count();
        test_wrap();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
